// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: synchronises the pins, deframes 11-bit frames and queues scan codes
// in a show-ahead FIFO. Optional frame watchdog enabled with `define PS2_RX_TIMEOUT_EN.
module ps2_keyboard_rx #(
  parameter int FIFO_AW        = 3,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = 1;

  logic [2:0]       sync_clk;
  logic [1:0]       sync_data;
  logic             fall;
  logic             bit_in;
  logic [3:0]       cnt;
  logic [9:0]       shift;
  logic             frame_ok;
  logic             push;
  logic [7:0]       push_data;
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic [7:0]       mem [DEPTH];
  logic             abort;

  // ps2_data has one stage less so the sampled bit lines up with sync_clk[1]
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_clk  <= 3'b111;
      sync_data <= 2'b11;
    end else begin
      sync_clk  <= {sync_clk[1:0], ps2_clk};
      sync_data <= {sync_data[0], ps2_data};
    end
  end

  assign fall   = sync_clk[2] & ~sync_clk[1];
  assign bit_in = sync_data[1];

  // shift holds {par, d[7:0], start} once ten bits are in; bit_in is the stop bit at cnt==10
  assign frame_ok = ~shift[0] & bit_in & (^shift[9:1]);

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
    end else if (fall) begin
      tmr <= TW'(TIMEOUT_CYCLES - 1);
    end else if (cnt != 4'd0 && tmr != '0) begin
      tmr <= tmr - TW'(1);
    end
  end

  assign abort = ~fall & (cnt != 4'd0) & (tmr == '0);
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      shift     <= 10'd0;
      push      <= 1'b0;
      push_data <= 8'd0;
      frame_err <= 1'b0;
    end else begin
      push      <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        if (cnt == 4'd10) begin
          cnt   <= 4'd0;
          shift <= 10'd0;
          if (frame_ok) begin
            push      <= 1'b1;
            push_data <= shift[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          shift <= {bit_in, shift[9:1]};
          cnt   <= cnt + 4'd1;
        end
      end else if (abort) begin
        cnt   <= 4'd0;
        shift <= 10'd0;
      end
    end
  end

  assign ready   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]) &&
                   (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]);
  assign do_pop  = rd_en & ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push = push & (~full | do_pop);
  assign data    = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule
